// File: rtl/wb_trace_cap.sv
// Trace capture unit: probes and triggers go into a circular buffer, which the CPU
// reads back over a 32-bit Wishbone slave. State | meaning: IDLE 0 idle | PRE 1 pre-fill | ARMED 2 hunt | POST 3 post-fill | DONE 4 held
module wb_trace_cap #(
    parameter int DATA_W = 42,
    parameter int DEPTH  = 256,
    parameter int TRIG_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] probe_i,
    input  logic              sample_en_i,
    input  logic [TRIG_N-1:0] trig_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [5:0]        wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_stall_o,
    output logic              irq_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    logic              comb;
    logic [TRIG_N-1:0] tmask, tval, tedge, trig_q, match;
    logic [AW-1:0]     pre, tidx, rdptr, wp, cnt, post_len, rd_phys, pre_wr;
    logic              triggered, wrapped, force_pend, irq;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;
    logic [127:0]      padded;

    logic              ack, stall, pend, rd_ok;
    logic [1:0]        rd_word;
    logic [31:0]       dat, reg_rdata, wr_val, word_sel;
    logic [3:0]        wadr;
    logic              req, is_ram, reg_we, wr_ctrl;
    logic              do_arm, do_abort, do_force;
    logic              and_hit, or_hit, hit, capturing, store, fire;
    logic              adr_unused;

    assign adr_unused = ^wbs_adr_i[1:0];
    assign wadr       = wbs_adr_i[5:2];
    assign req        = wbs_cyc_i & wbs_stb_i & ~ack & ~pend;
    assign is_ram     = (wadr[3:2] == 2'b10);
    assign reg_we     = req & wbs_we_i & ~is_ram;
    assign wr_ctrl    = reg_we & (wadr == 4'd0);
    assign do_arm     = wr_ctrl & wr_val[0];
    assign do_abort   = wr_ctrl & wr_val[1];
    assign do_force   = wr_ctrl & wr_val[2];

    always_comb begin
        reg_rdata = '0;
        case (wadr)
            4'd0: reg_rdata[8] = comb;
            4'd1: reg_rdata = {26'd0, wrapped, triggered, 1'b0, state};
            4'd2: reg_rdata[TRIG_N-1:0] = tmask;
            4'd3: reg_rdata[TRIG_N-1:0] = tval;
            4'd4: reg_rdata[TRIG_N-1:0] = tedge;
            4'd5: reg_rdata[AW-1:0] = pre;
            4'd6: reg_rdata[AW-1:0] = tidx;
            4'd7: reg_rdata[AW-1:0] = rdptr;
            default: reg_rdata = '0;
        endcase
    end

    // Byte lanes not selected keep the register's current value.
    always_comb begin
        wr_val = reg_rdata;
        for (int i = 0; i < 4; i++)
            if (wbs_sel_i[i]) wr_val[8*i +: 8] = wbs_dat_i[8*i +: 8];
    end

    assign pre_wr = (wr_val > 32'(DEPTH - 1)) ? AW'(DEPTH - 1) : wr_val[AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comb  <= 1'b0;
            tmask <= '0;
            tval  <= '0;
            tedge <= '0;
            pre   <= '0;
            rdptr <= '0;
        end else if (reg_we) begin
            case (wadr)
                4'd0: comb  <= wr_val[8];
                4'd2: tmask <= wr_val[TRIG_N-1:0];
                4'd3: tval  <= wr_val[TRIG_N-1:0];
                4'd4: tedge <= wr_val[TRIG_N-1:0];
                4'd5: pre   <= pre_wr;
                4'd7: rdptr <= wr_val[AW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) trig_q <= '0;
        else        trig_q <= trig_i;
    end

    // Edge mode: the line must have just moved onto the selected value.
    always_comb begin
        match = '0;
        for (int k = 0; k < TRIG_N; k++)
            match[k] = (trig_i[k] == tval[k]) && (!tedge[k] || (trig_q[k] != tval[k]));
    end

    assign and_hit   = (tmask != '0) && ((match | ~tmask) == '1);
    assign or_hit    = |(match & tmask);
    assign hit       = comb ? or_hit : and_hit;
    assign capturing = state inside {S_PRE, S_ARMED, S_POST};
    assign store     = sample_en_i & capturing & ~do_arm & ~do_abort;
    assign fire      = (state == S_ARMED) & store & (hit | force_pend | do_force);
    assign post_len  = AW'(DEPTH - 1) - pre;
    assign rd_phys   = wp + rdptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wp         <= '0;
            cnt        <= '0;
            tidx       <= '0;
            triggered  <= 1'b0;
            wrapped    <= 1'b0;
            force_pend <= 1'b0;
            irq        <= 1'b0;
        end else if (do_abort) begin
            state      <= S_IDLE;
            force_pend <= 1'b0;
            irq        <= 1'b0;
        end else if (do_arm) begin
            wp         <= '0;
            cnt        <= pre;
            triggered  <= 1'b0;
            wrapped    <= 1'b0;
            force_pend <= 1'b0;
            irq        <= 1'b0;
            state      <= (pre == '0) ? S_ARMED : S_PRE;
        end else begin
            // A force outside a qualified cycle waits for the next stored sample.
            if (do_force && state == S_ARMED && !fire) force_pend <= 1'b1;
            case (state)
                S_PRE: if (store) begin
                    wp <= wp + 1'b1;
                    if (cnt == AW'(1)) state <= S_ARMED;
                    else               cnt   <= cnt - 1'b1;
                end
                S_ARMED: if (store) begin
                    wp <= wp + 1'b1;
                    if (wp == AW'(DEPTH - 1)) wrapped <= 1'b1;
                    if (fire) begin
                        triggered  <= 1'b1;
                        tidx       <= pre;
                        force_pend <= 1'b0;
                        if (post_len == '0) begin
                            state <= S_DONE;
                            irq   <= 1'b1;
                        end else begin
                            cnt   <= post_len;
                            state <= S_POST;
                        end
                    end
                end
                S_POST: if (store) begin
                    wp <= wp + 1'b1;
                    if (cnt == AW'(1)) begin
                        state <= S_DONE;
                        irq   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store)         mem[wp] <= probe_i;
        if (req && is_ram) mem_q   <= mem[rd_phys];
    end

    always_comb begin
        padded = '0;
        padded[DATA_W-1:0] = mem_q;
    end

    always_comb begin
        case (rd_word)
            2'd0:    word_sel = padded[31:0];
            2'd1:    word_sel = padded[63:32];
            2'd2:    word_sel = padded[95:64];
            default: word_sel = padded[127:96];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            stall   <= 1'b0;
            pend    <= 1'b0;
            dat     <= '0;
            rd_word <= '0;
            rd_ok   <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (pend) begin
                pend  <= 1'b0;
                stall <= 1'b0;
                ack   <= 1'b1;
                dat   <= rd_ok ? word_sel : '0;
            end else if (req) begin
                if (is_ram) begin
                    pend    <= 1'b1;
                    stall   <= 1'b1;
                    rd_word <= wadr[1:0];
                    rd_ok   <= (state == S_IDLE) || (state == S_DONE);
                end else begin
                    ack <= 1'b1;
                    dat <= reg_rdata;
                end
            end
        end
    end

    assign wbs_dat_o   = dat;
    assign wbs_ack_o   = ack;
    assign wbs_stall_o = stall;
    assign irq_o       = irq;
endmodule

// File: tb/tb_wb_trace_cap.sv
// Directed bench for wb_trace_cap with DEPTH=16 and a counting probe.
module tb_wb_trace_cap;
    localparam int DW    = 42;
    localparam int DEPTH = 16;
    localparam int TN    = 2;

    localparam logic [5:0] A_CTRL = 6'h00, A_STAT = 6'h04, A_TMASK = 6'h08, A_TVAL = 6'h0C;
    localparam logic [5:0] A_TEDGE = 6'h10, A_PRE = 6'h14, A_TIDX = 6'h18, A_RDPTR = 6'h1C;
    localparam logic [5:0] A_RD0 = 6'h20, A_RD1 = 6'h24, A_RD2 = 6'h28, A_UNMAP = 6'h30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] probe_i = '0;
    logic          sample_en_i = 1'b1;
    logic [TN-1:0] trig_i = '0;
    logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [5:0]    wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic [3:0]    wbs_sel_i = '0;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o, wbs_stall_o, irq_o;

    int total = 0;
    int bad   = 0;

    int       t1 = 1000, t2 = 1000;
    logic [1:0] v0 = 2'b00, v1 = 2'b00, v2 = 2'b00;
    bit       en_even = 1'b0;

    always #5 clk = ~clk;

    wb_trace_cap #(.DATA_W(DW), .DEPTH(DEPTH), .TRIG_N(TN)) dut (
        .clk(clk), .rst_n(rst_n), .probe_i(probe_i), .sample_en_i(sample_en_i),
        .trig_i(trig_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_stall_o(wbs_stall_o), .irq_o(irq_o)
    );

    task automatic drive_aux();
        sample_en_i = en_even ? ~probe_i[0] : 1'b1;
        if (longint'(probe_i) >= longint'(t2))      trig_i = v2;
        else if (longint'(probe_i) >= longint'(t1)) trig_i = v1;
        else                                        trig_i = v0;
    endtask

    task automatic set_probe(input int v);
        probe_i = DW'(v);
        drive_aux();
    endtask

    task automatic tick();
        @(negedge clk);
        probe_i = probe_i + 1'b1;
        drive_aux();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rdv, output int lat, output logic st1);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        lat = 0; st1 = 1'b0;
        do begin
            tick();
            lat++;
            if (lat == 1) st1 = wbs_stall_o;
        end while (wbs_ack_o !== 1'b1 && lat < 8);
        rdv = wbs_dat_o;
        chk("wb_ack", {31'd0, wbs_ack_o}, 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] x; int l; logic s;
        wb(1'b1, a, d, 4'hF, x, l, s);
    endtask

    task automatic chk_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] x; int l; logic s;
        wb(1'b0, a, 32'd0, 4'hF, x, l, s);
        chk(tag, x, exp);
    endtask

    task automatic chk_rdata(input string tag, input int idx, input logic [31:0] exp);
        wr(A_RDPTR, 32'(idx));
        chk_reg(tag, A_RD0, exp);
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (irq_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, irq_o}, 32'd1);
    endtask

    task automatic wait_probe(input string tag, input int v);
        int n = 0;
        while (probe_i != DW'(v) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(probe_i), 32'(v));
    endtask

    task automatic chk_reset_regs(input string tag);
        chk({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd0);
        chk({tag, "_stall"}, {31'd0, wbs_stall_o}, 32'd0);
        chk({tag, "_irq"}, {31'd0, irq_o}, 32'd0);
        chk({tag, "_dat"}, wbs_dat_o, 32'd0);
        chk_reg({tag, "_ctrl"}, A_CTRL, 32'd0);
        chk_reg({tag, "_status"}, A_STAT, 32'd0);
        chk_reg({tag, "_tmask"}, A_TMASK, 32'd0);
        chk_reg({tag, "_tval"}, A_TVAL, 32'd0);
        chk_reg({tag, "_tedge"}, A_TEDGE, 32'd0);
        chk_reg({tag, "_pre"}, A_PRE, 32'd0);
        chk_reg({tag, "_tidx"}, A_TIDX, 32'd0);
        chk_reg({tag, "_rdptr"}, A_RDPTR, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x; int lat; logic st1;

        set_probe(0);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk_reset_regs("rst0");
        chk_reg("unmapped", A_UNMAP, 32'd0);

        // Edge trigger at count 20, PRE=4.
        wr(A_TMASK, 1); wr(A_TVAL, 1); wr(A_TEDGE, 1); wr(A_PRE, 4);
        t1 = 20; v0 = 2'b00; v1 = 2'b01; t2 = 1000; en_even = 1'b0;
        set_probe(0);
        wr(A_CTRL, 32'h001);
        wait_irq("t1_irq");
        chk_reg("t1_status", A_STAT, 32'h34);
        chk_reg("t1_tidx", A_TIDX, 32'd4);
        for (int i = 0; i < DEPTH; i++) chk_rdata("t1_rdata", i, 32'(16 + i));
        wr(A_RDPTR, 32'd3);
        wb(1'b0, A_RD0, 32'd0, 4'hF, x, lat, st1);
        chk("t1_rd_lat", 32'(lat), 32'd2);
        chk("t1_rd_stall", {31'd0, st1}, 32'd1);
        chk("t1_rd_val", x, 32'd19);
        chk_reg("t1_word1", A_RD1, 32'd0);
        chk_reg("t1_word2", A_RD2, 32'd0);
        wb(1'b0, A_STAT, 32'd0, 4'hF, x, lat, st1);
        chk("t1_reg_lat", 32'(lat), 32'd1);
        chk("t1_reg_stall", {31'd0, st1}, 32'd0);
        wr(A_RDPTR, 32'd17);
        chk_reg("t1_rdptr_wrap", A_RDPTR, 32'd1);
        chk_reg("t1_rdptr_wrap_data", A_RD0, 32'd17);

        // Qualifier on even counts only.
        en_even = 1'b1;
        set_probe(0);
        wr(A_CTRL, 32'h001);
        wait_irq("t2_irq");
        chk_reg("t2_tidx", A_TIDX, 32'd4);
        chk_rdata("t2_rd0", 0, 32'd12);
        chk_rdata("t2_rd4", 4, 32'd20);
        chk_rdata("t2_rd5", 5, 32'd22);
        chk_rdata("t2_rd15", 15, 32'd42);

        // Edge landing in an unqualified cycle is ignored.
        t1 = 21;
        set_probe(0);
        wr(A_CTRL, 32'h001);
        repeat (60) tick();
        chk("t2b_irq", {31'd0, irq_o}, 32'd0);
        chk_reg("t2b_status", A_STAT, 32'h22);
        wr(A_CTRL, 32'h002);
        chk_reg("t2b_abort", A_STAT, 32'h20);
        en_even = 1'b0;

        // Two-line level trigger, AND then OR.
        wr(A_TMASK, 3); wr(A_TVAL, 3); wr(A_TEDGE, 0); wr(A_PRE, 2);
        t1 = 20; v1 = 2'b01; t2 = 25; v2 = 2'b11; v0 = 2'b00;
        set_probe(0);
        wr(A_CTRL, 32'h001);
        wait_irq("t3and_irq");
        chk_reg("t3and_tidx", A_TIDX, 32'd2);
        chk_rdata("t3and_trig", 2, 32'd25);
        chk_rdata("t3and_rd0", 0, 32'd23);
        set_probe(0);
        wr(A_CTRL, 32'h101);
        wait_irq("t3or_irq");
        chk_reg("t3or_ctrl", A_CTRL, 32'h100);
        chk_rdata("t3or_trig", 2, 32'd20);
        chk_rdata("t3or_rd0", 0, 32'd18);
        wr(A_CTRL, 32'h003);
        chk("t3_abort_irq", {31'd0, irq_o}, 32'd0);
        chk_reg("t3_abort_wins", A_STAT, 32'h30);

        // PRE clamp: trigger becomes the newest sample.
        wr(A_PRE, DEPTH + 5);
        chk_reg("t4_pre_clamp", A_PRE, 32'd15);
        wb(1'b1, A_PRE, 32'd5, 4'b0000, x, lat, st1);
        chk_reg("t4_pre_sel0", A_PRE, 32'd15);
        wr(A_TMASK, 1); wr(A_TVAL, 1); wr(A_TEDGE, 0);
        t1 = 30; v1 = 2'b01; t2 = 1000; v0 = 2'b00;
        set_probe(0);
        wr(A_CTRL, 32'h001);
        wait_irq("t4_irq");
        chk_reg("t4_tidx", A_TIDX, 32'd15);
        chk_rdata("t4_rd15", 15, 32'd30);
        chk_rdata("t4_rd14", 14, 32'd29);
        chk_rdata("t4_rd0", 0, 32'd15);

        // Force trigger with no mask.
        wr(A_TMASK, 0); wr(A_PRE, 2);
        set_probe(0);
        wr(A_CTRL, 32'h001);
        wait_probe("tf_reach", 9);
        wr(A_CTRL, 32'h004);
        wait_irq("tf_irq");
        chk_reg("tf_tidx", A_TIDX, 32'd2);
        chk_rdata("tf_trig", 2, 32'd9);
        chk_rdata("tf_rd0", 0, 32'd7);

        // Abort during POST keeps triggered until next arm.
        wr(A_TMASK, 1); wr(A_TVAL, 1); wr(A_TEDGE, 1); wr(A_PRE, 4);
        t1 = 20; v1 = 2'b01;
        set_probe(0);
        wr(A_CTRL, 32'h001);
        wait_probe("t5_reach", 22);
        chk_reg("t5_post", A_STAT, 32'h33);
        wr(A_CTRL, 32'h002);
        chk("t5_irq", {31'd0, irq_o}, 32'd0);
        chk_reg("t5_abort", A_STAT, 32'h30);
        wr(A_CTRL, 32'h001);
        chk_reg("t5_rearm", A_STAT, 32'h01);
        wr(A_CTRL, 32'h002);

        // Reset pulse while ARMED.
        wr(A_TMASK, 1); wr(A_TVAL, 1); wr(A_TEDGE, 0); wr(A_PRE, 2); wr(A_RDPTR, 5);
        t1 = 1000;
        set_probe(0);
        wr(A_CTRL, 32'h101);
        repeat (10) tick();
        chk_reg("t6_armed", A_STAT, 32'h02);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_regs("t6");
        for (int i = 0; i < 2; i++) begin
            wb(1'b0, A_RD0, 32'd0, 4'hF, x, lat, st1);
            chk("t6_rd_stall", {31'd0, st1}, 32'd1);
            chk("t6_rd_lat", 32'(lat), 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
